// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: takes one issued instruction at a time from the issue queue,
// runs the selected data-SRAM access and returns read data, completions or evicted lines.
module bank_sram_ctrl #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iq_sc_valid_i,
  output logic                  iq_sc_ready_o,
  input  logic [1:0]            iq_sc_channel_id_i,
  input  logic [2:0]            iq_sc_opcode_i,
  input  logic [6:0]            iq_sc_set_way_offset_i,
  input  logic [7:0]            iq_sc_wbuffer_id_i,
  input  logic [2:0]            iq_sc_xbar_rob_num_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
  output logic                  sram_cen_o,
  output logic                  sram_wen_o,
  output logic [6:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  wbuf_ren_o,
  output logic [7:0]            wbuf_rid_o,
  input  logic [DATA_WIDTH-1:0] wbuf_rdata_i,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_ch_id_o,
  output logic [2:0]            rsp_rob_num_o,
  output logic                  rsp_is_write_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  sc_biu_wvalid_o,
  input  logic                  sc_biu_wready_i,
  output logic [6:0]            sc_biu_waddr_o,
  output logic [1:0]            sc_biu_wstrb_o,
  output logic [DATA_WIDTH-1:0] sc_biu_wdata_o,
  output logic [1:0]            fsm_state_o
);

  // Handshake: an instruction transfers on a cycle where iq_sc_valid_i and iq_sc_ready_o
  // are both high; the issuer holds valid and payload stable until then. The BIU
  // write-back transfers when sc_biu_wvalid_o and sc_biu_wready_i are both high, with the
  // payload held stable while waiting. Responses have no backpressure.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUF_RD  = 2'd1,
    SRAM_RD = 2'd2,
    WB_SEND = 2'd3
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_LFILL = 2'd2;
  localparam logic [1:0] OP_WB    = 2'd3;

  state_e                  state_q, state_d;
  logic [1:0]              ch_q;
  logic [2:0]              rob_q;
  logic [1:0]              op_q;
  logic [6:0]              addr_q;
  logic [1:0]              strb_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic                    accept;
  logic                    unused_opcode_bit;

  assign unused_opcode_bit = iq_sc_opcode_i[2];
  assign accept            = iq_sc_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Writes and linefills (opcode bit 0 clear) both start with a buffer read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = iq_sc_opcode_i[0] ? SRAM_RD : BUF_RD;
      BUF_RD:  state_d = IDLE;
      SRAM_RD: state_d = (op_q == OP_WB) ? WB_SEND : IDLE;
      WB_SEND: if (sc_biu_wready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q      <= '0;
      rob_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      strb_q    <= '0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        ch_q   <= iq_sc_channel_id_i;
        rob_q  <= iq_sc_xbar_rob_num_i;
        op_q   <= iq_sc_opcode_i[1:0];
        addr_q <= iq_sc_set_way_offset_i;
        strb_q <= {iq_sc_cacheline_state_offset1_i == 2'b11,
                   iq_sc_cacheline_state_offset0_i == 2'b11};
      end
      if ((state_q == SRAM_RD) && (op_q == OP_WB)) begin
        wb_data_q <= sram_rdata_i;
      end
    end
  end

  always_comb begin
    iq_sc_ready_o   = (state_q == IDLE);
    sram_cen_o      = 1'b0;
    sram_wen_o      = 1'b0;
    sram_addr_o     = addr_q;
    sram_wdata_o    = '0;
    wbuf_ren_o      = 1'b0;
    wbuf_rid_o      = '0;
    rsp_valid_o     = 1'b0;
    rsp_is_write_o  = 1'b0;
    rsp_data_o      = '0;
    sc_biu_wvalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (iq_sc_opcode_i[0]) begin
            sram_cen_o  = 1'b1;
            sram_addr_o = iq_sc_set_way_offset_i;
          end else begin
            wbuf_ren_o = 1'b1;
            wbuf_rid_o = iq_sc_wbuffer_id_i;
          end
        end
      end
      BUF_RD: begin
        sram_cen_o     = 1'b1;
        sram_wen_o     = 1'b1;
        sram_wdata_o   = wbuf_rdata_i;
        rsp_valid_o    = 1'b1;
        rsp_is_write_o = (op_q == OP_WRITE);
        rsp_data_o     = (op_q == OP_LFILL) ? wbuf_rdata_i : '0;
      end
      SRAM_RD: begin
        if (op_q == OP_READ) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = sram_rdata_i;
        end
      end
      WB_SEND: sc_biu_wvalid_o = 1'b1;
      default: ;
    endcase
  end

  assign rsp_ch_id_o    = ch_q;
  assign rsp_rob_num_o  = rob_q;
  assign sc_biu_waddr_o = addr_q;
  assign sc_biu_wstrb_o = strb_q;
  assign sc_biu_wdata_o = wb_data_q;
  assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Directed bench for bank_sram_ctrl: table of single-instruction vectors plus
// hand-written write-back, back-to-back and reset-during-write-back sequences.
module tb_bank_sram_ctrl;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iq_sc_valid_i = 1'b0;
  logic          iq_sc_ready_o;
  logic [1:0]    iq_sc_channel_id_i = '0;
  logic [2:0]    iq_sc_opcode_i = '0;
  logic [6:0]    iq_sc_set_way_offset_i = '0;
  logic [7:0]    iq_sc_wbuffer_id_i = '0;
  logic [2:0]    iq_sc_xbar_rob_num_i = '0;
  logic [1:0]    off0 = '0;
  logic [1:0]    off1 = '0;
  logic          sram_cen_o, sram_wen_o;
  logic [6:0]    sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i = '0;
  logic          wbuf_ren_o;
  logic [7:0]    wbuf_rid_o;
  logic [DW-1:0] wbuf_rdata_i = '0;
  logic          rsp_valid_o;
  logic [1:0]    rsp_ch_id_o;
  logic [2:0]    rsp_rob_num_o;
  logic          rsp_is_write_o;
  logic [DW-1:0] rsp_data_o;
  logic          sc_biu_wvalid_o;
  logic          sc_biu_wready_i = 1'b0;
  logic [6:0]    sc_biu_waddr_o;
  logic [1:0]    sc_biu_wstrb_o;
  logic [DW-1:0] sc_biu_wdata_o;
  logic [1:0]    fsm_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_cnt = 0;
  int wb_cnt = 0;
  int exp_rsp_cnt = 0;
  int exp_wb_cnt = 0;

  localparam logic [DW-1:0] JUNK_A = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] JUNK_B = {4{32'h0BAD_F00D}};

  bank_sram_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .iq_sc_valid_i(iq_sc_valid_i), .iq_sc_ready_o(iq_sc_ready_o),
    .iq_sc_channel_id_i(iq_sc_channel_id_i), .iq_sc_opcode_i(iq_sc_opcode_i),
    .iq_sc_set_way_offset_i(iq_sc_set_way_offset_i), .iq_sc_wbuffer_id_i(iq_sc_wbuffer_id_i),
    .iq_sc_xbar_rob_num_i(iq_sc_xbar_rob_num_i),
    .iq_sc_cacheline_state_offset0_i(off0), .iq_sc_cacheline_state_offset1_i(off1),
    .sram_cen_o(sram_cen_o), .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .wbuf_ren_o(wbuf_ren_o), .wbuf_rid_o(wbuf_rid_o), .wbuf_rdata_i(wbuf_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ch_id_o(rsp_ch_id_o), .rsp_rob_num_o(rsp_rob_num_o),
    .rsp_is_write_o(rsp_is_write_o), .rsp_data_o(rsp_data_o),
    .sc_biu_wvalid_o(sc_biu_wvalid_o), .sc_biu_wready_i(sc_biu_wready_i),
    .sc_biu_waddr_o(sc_biu_waddr_o), .sc_biu_wstrb_o(sc_biu_wstrb_o),
    .sc_biu_wdata_o(sc_biu_wdata_o), .fsm_state_o(fsm_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
    if (!rst && sc_biu_wvalid_o && sc_biu_wready_i) wb_cnt <= wb_cnt + 1;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input logic [2:0] op, input logic [1:0] ch, input logic [2:0] rob,
                             input logic [6:0] addr, input logic [7:0] wbid,
                             input logic [1:0] s0, input logic [1:0] s1);
    iq_sc_valid_i          = 1'b1;
    iq_sc_opcode_i         = op;
    iq_sc_channel_id_i     = ch;
    iq_sc_xbar_rob_num_i   = rob;
    iq_sc_set_way_offset_i = addr;
    iq_sc_wbuffer_id_i     = wbid;
    off0                   = s0;
    off1                   = s1;
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    ch;
    logic [2:0]    rob;
    logic [6:0]    addr;
    logic [7:0]    wbid;
    logic [DW-1:0] data;
    logic          exp_buf;
    logic          exp_is_write;
    logic [DW-1:0] exp_rsp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3'd1, 2'd2, 3'd5, 7'h15, 8'h00, {16{8'hA5}}, 1'b0, 1'b0, {16{8'hA5}}};
    vecs[1] = '{3'd0, 2'd1, 3'd3, 7'h40, 8'h3C, 128'h1234, 1'b1, 1'b1, 128'h0};
    vecs[2] = '{3'd2, 2'd3, 3'd7, 7'h02, 8'h07, 128'hBEEF, 1'b1, 1'b0, 128'hBEEF};
    vecs[3] = '{3'd5, 2'd0, 3'd0, 7'h00, 8'h55, 128'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 128'h0123_4567_89AB_CDEF};
    vecs[4] = '{3'd4, 2'd0, 3'd6, 7'h7F, 8'hFF, {DW{1'b1}}, 1'b1, 1'b1, 128'h0};

    // reset state
    #2;
    check("rst_ready", iq_sc_ready_o, 1);
    check("rst_cen", sram_cen_o, 0);
    check("rst_ren", wbuf_ren_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_wvalid", sc_biu_wvalid_o, 0);
    check("rst_ch", rsp_ch_id_o, 0);
    check("rst_rob", rsp_rob_num_o, 0);
    check("rst_waddr", sc_biu_waddr_o, 0);
    check("rst_wdata", sc_biu_wdata_o, 0);
    check("rst_state", fsm_state_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven single instructions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_instr(vecs[i].op, vecs[i].ch, vecs[i].rob, vecs[i].addr, vecs[i].wbid, 2'b00, 2'b00);
      sram_rdata_i = JUNK_A;
      wbuf_rdata_i = JUNK_B;
      #1;
      check($sformatf("v%0d_acc_ready", i), iq_sc_ready_o, 1);
      check($sformatf("v%0d_acc_ren", i), wbuf_ren_o, vecs[i].exp_buf);
      check($sformatf("v%0d_acc_cen", i), sram_cen_o, !vecs[i].exp_buf);
      if (vecs[i].exp_buf) begin
        check($sformatf("v%0d_acc_rid", i), wbuf_rid_o, vecs[i].wbid);
      end else begin
        check($sformatf("v%0d_acc_wen", i), sram_wen_o, 0);
        check($sformatf("v%0d_acc_addr", i), sram_addr_o, vecs[i].addr);
      end
      @(negedge clk);
      iq_sc_valid_i = 1'b0;
      if (vecs[i].exp_buf) wbuf_rdata_i = vecs[i].data;
      else sram_rdata_i = vecs[i].data;
      #1;
      exp_rsp_cnt++;
      check($sformatf("v%0d_t1_ready", i), iq_sc_ready_o, 0);
      check($sformatf("v%0d_t1_rsp_valid", i), rsp_valid_o, 1);
      check($sformatf("v%0d_t1_is_write", i), rsp_is_write_o, vecs[i].exp_is_write);
      check($sformatf("v%0d_t1_rsp_data", i), rsp_data_o, vecs[i].exp_rsp);
      check($sformatf("v%0d_t1_ch", i), rsp_ch_id_o, vecs[i].ch);
      check($sformatf("v%0d_t1_rob", i), rsp_rob_num_o, vecs[i].rob);
      check($sformatf("v%0d_t1_cen", i), sram_cen_o, vecs[i].exp_buf);
      check($sformatf("v%0d_t1_ren", i), wbuf_ren_o, 0);
      if (vecs[i].exp_buf) begin
        check($sformatf("v%0d_t1_wen", i), sram_wen_o, 1);
        check($sformatf("v%0d_t1_waddr", i), sram_addr_o, vecs[i].addr);
        check($sformatf("v%0d_t1_wdata", i), sram_wdata_o, vecs[i].data);
      end
      @(negedge clk);
      #1;
      check($sformatf("v%0d_t2_ready", i), iq_sc_ready_o, 1);
      check($sformatf("v%0d_t2_rsp_valid", i), rsp_valid_o, 0);
      check($sformatf("v%0d_t2_cen", i), sram_cen_o, 0);
    end

    // write-back with BIU stalling for 4 cycles
    @(negedge clk);
    drive_instr(3'd3, 2'd1, 3'd2, 7'h7F, 8'h00, 2'b11, 2'b01);
    sram_rdata_i = JUNK_A;
    #1;
    check("wb_acc_cen", sram_cen_o, 1);
    check("wb_acc_wen", sram_wen_o, 0);
    check("wb_acc_addr", sram_addr_o, 7'h7F);
    @(negedge clk);
    iq_sc_valid_i = 1'b0;
    sram_rdata_i  = {8{16'hC0DE}};
    #1;
    check("wb_t1_rsp_valid", rsp_valid_o, 0);
    check("wb_t1_wvalid", sc_biu_wvalid_o, 0);
    check("wb_t1_ready", iq_sc_ready_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sram_rdata_i = JUNK_B;
      #1;
      check($sformatf("wb_stall%0d_wvalid", c), sc_biu_wvalid_o, 1);
      check($sformatf("wb_stall%0d_waddr", c), sc_biu_waddr_o, 7'h7F);
      check($sformatf("wb_stall%0d_wstrb", c), sc_biu_wstrb_o, 2'b01);
      check($sformatf("wb_stall%0d_wdata", c), sc_biu_wdata_o, {8{16'hC0DE}});
      check($sformatf("wb_stall%0d_ready", c), iq_sc_ready_o, 0);
      check($sformatf("wb_stall%0d_cen", c), sram_cen_o, 0);
    end
    @(negedge clk);
    sc_biu_wready_i = 1'b1;
    exp_wb_cnt++;
    #1;
    check("wb_hs_wvalid", sc_biu_wvalid_o, 1);
    check("wb_hs_ready", iq_sc_ready_o, 0);
    @(negedge clk);
    sc_biu_wready_i = 1'b0;
    #1;
    check("wb_after_ready", iq_sc_ready_o, 1);
    check("wb_after_wvalid", sc_biu_wvalid_o, 0);

    // write-back with no dirty half is still sent, BIU ready at once
    @(negedge clk);
    drive_instr(3'd3, 2'd0, 3'd1, 7'h11, 8'h00, 2'b01, 2'b10);
    @(negedge clk);
    iq_sc_valid_i = 1'b0;
    sram_rdata_i  = 128'h77;
    @(negedge clk);
    sc_biu_wready_i = 1'b1;
    exp_wb_cnt++;
    #1;
    check("wb0_wvalid", sc_biu_wvalid_o, 1);
    check("wb0_wstrb", sc_biu_wstrb_o, 2'b00);
    check("wb0_waddr", sc_biu_waddr_o, 7'h11);
    check("wb0_wdata", sc_biu_wdata_o, 128'h77);
    @(negedge clk);
    sc_biu_wready_i = 1'b0;
    #1;
    check("wb0_after_ready", iq_sc_ready_o, 1);

    // back-to-back: op 1 then op 0 with valid held high
    @(negedge clk);
    drive_instr(3'd1, 2'd3, 3'd4, 7'h21, 8'h00, 2'b00, 2'b00);
    #1;
    check("b2b_a_cen", sram_cen_o, 1);
    @(posedge clk);
    #1;
    drive_instr(3'd0, 2'd2, 3'd1, 7'h22, 8'h99, 2'b00, 2'b00);
    @(negedge clk);
    sram_rdata_i = 128'hAAAA;
    wbuf_rdata_i = 128'h5555;
    exp_rsp_cnt++;
    #1;
    check("b2b_t1_ready", iq_sc_ready_o, 0);
    check("b2b_t1_ren", wbuf_ren_o, 0);
    check("b2b_t1_rsp_data", rsp_data_o, 128'hAAAA);
    check("b2b_t1_ch", rsp_ch_id_o, 2'd3);
    @(negedge clk);
    #1;
    check("b2b_t2_ready", iq_sc_ready_o, 1);
    check("b2b_t2_ren", wbuf_ren_o, 1);
    check("b2b_t2_rid", wbuf_rid_o, 8'h99);
    check("b2b_t2_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    iq_sc_valid_i = 1'b0;
    exp_rsp_cnt++;
    #1;
    check("b2b_t3_is_write", rsp_is_write_o, 1);
    check("b2b_t3_ch", rsp_ch_id_o, 2'd2);
    check("b2b_t3_wdata", sram_wdata_o, 128'h5555);
    @(negedge clk);
    #1;
    check("b2b_rsp_count", rsp_cnt, exp_rsp_cnt);

    // reset pulsed during WB_SEND
    @(negedge clk);
    drive_instr(3'd3, 2'd1, 3'd3, 7'h33, 8'h00, 2'b11, 2'b11);
    @(negedge clk);
    iq_sc_valid_i = 1'b0;
    sram_rdata_i  = 128'hFACE;
    @(negedge clk);
    #1;
    check("rwb_wvalid_pre", sc_biu_wvalid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rwb_wvalid_async", sc_biu_wvalid_o, 0);
    check("rwb_ready_async", iq_sc_ready_o, 1);
    check("rwb_waddr_async", sc_biu_waddr_o, 0);
    check("rwb_wdata_async", sc_biu_wdata_o, 0);
    @(negedge clk);
    rst = 1'b0;
    sc_biu_wready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rwb_wvalid_after", sc_biu_wvalid_o, 0);
    check("rwb_ready_after", iq_sc_ready_o, 1);
    check("rwb_wb_count", wb_cnt, exp_wb_cnt);
    check("rwb_rsp_count", rsp_cnt, exp_rsp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
